// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters (P = MEM stage,
// D = debug/loader) and the single-port data memory.
interface dmem_arbiter_if #(
  parameter int WORD_WIDTH = 32
);
  logic                  halt;

  logic                  p_req;
  logic                  p_wen;
  logic [2:0]            p_type;
  logic [WORD_WIDTH-1:0] p_addr;
  logic [WORD_WIDTH-1:0] p_wd;
  logic                  p_ack;
  logic [WORD_WIDTH-1:0] p_rd;
  logic                  p_stall;

  logic                  d_req;
  logic                  d_wen;
  logic [2:0]            d_type;
  logic [WORD_WIDTH-1:0] d_addr;
  logic [WORD_WIDTH-1:0] d_wd;
  logic                  d_ack;
  logic [WORD_WIDTH-1:0] d_rd;

  logic                  m_en;
  logic                  m_wen;
  logic [2:0]            m_type;
  logic [WORD_WIDTH-1:0] m_addr;
  logic [WORD_WIDTH-1:0] m_wd;
  logic [WORD_WIDTH-1:0] m_rd;

  logic                  owner;

  // Environment side: requesters plus the memory read-data return.
  modport master (
    output halt,
    output p_req, p_wen, p_type, p_addr, p_wd,
    input  p_ack, p_rd, p_stall,
    output d_req, d_wen, d_type, d_addr, d_wd,
    input  d_ack, d_rd,
    input  m_en, m_wen, m_type, m_addr, m_wd,
    output m_rd,
    input  owner
  );

  // Arbiter side.
  modport slave (
    input  halt,
    input  p_req, p_wen, p_type, p_addr, p_wd,
    output p_ack, p_rd, p_stall,
    input  d_req, d_wen, d_type, d_addr, d_wd,
    output d_ack, d_rd,
    output m_en, m_wen, m_type, m_addr, m_wd,
    input  m_rd,
    output owner
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-way arbiter and wait-state sequencer for the single-port data memory,
// shared between the MEM stage (P) and the debug/loader port (D).
module dmem_arbiter #(
  parameter int WORD_WIDTH   = 32,
  parameter int WAIT_STATES  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  dmem_arbiter_if.slave bus
);

  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(WAIT_STATES);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [SW-1:0]         starve;
  logic                  owner_q;
  logic                  wen_q;
  logic [2:0]            type_q;
  logic [WORD_WIDTH-1:0] addr_q;
  logic [WORD_WIDTH-1:0] wd_q;
  logic [WORD_WIDTH-1:0] rd_q;
  logic                  grant_d;

  // P wins contention until it has been granted STARVE_LIMIT times over a waiting D.
  always_comb begin
    grant_d = bus.d_req & (~bus.p_req | (starve == STARVE_MAX));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      starve  <= '0;
      owner_q <= 1'b0;
      wen_q   <= 1'b0;
      type_q  <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      rd_q    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!bus.halt && (bus.p_req || bus.d_req)) begin
            owner_q <= grant_d;
            wen_q   <= grant_d ? bus.d_wen  : bus.p_wen;
            type_q  <= grant_d ? bus.d_type : bus.p_type;
            addr_q  <= grant_d ? bus.d_addr : bus.p_addr;
            wd_q    <= grant_d ? bus.d_wd   : bus.p_wd;
            cnt     <= '0;
            state   <= BUSY;
            if (grant_d) begin
              starve <= '0;
            end else if (bus.d_req && (starve != STARVE_MAX)) begin
              starve <= starve + SW'(1);
            end
          end
        end
        BUSY: begin
          if (cnt == CNT_LAST) begin
            rd_q  <= bus.m_rd;
            state <= ACK;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory strobes decode registered state only, so reset drops them immediately.
  assign bus.m_en    = (state == BUSY);
  assign bus.m_wen   = (state == BUSY) && (cnt == CNT_LAST) && wen_q;
  assign bus.m_type  = type_q;
  assign bus.m_addr  = addr_q;
  assign bus.m_wd    = wd_q;

  assign bus.p_ack   = (state == ACK) && !owner_q;
  assign bus.d_ack   = (state == ACK) &&  owner_q;
  assign bus.p_rd    = rd_q;
  assign bus.d_rd    = rd_q;
  assign bus.p_stall = bus.p_req & ~bus.p_ack;
  assign bus.owner   = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: one instance with one wait state, one with none.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          sel;
  logic          halt;
  logic          p_req, p_wen, d_req, d_wen;
  logic [2:0]    p_type, d_type;
  logic [W-1:0]  p_addr, p_wd, d_addr, d_wd;
  logic          mem_load;
  logic [W-1:0]  mem [0:31];

  int n_tests = 0;
  int n_fail  = 0;

  dmem_arbiter_if #(.WORD_WIDTH(W)) bus1 ();
  dmem_arbiter_if #(.WORD_WIDTH(W)) bus0 ();

  dmem_arbiter #(.WORD_WIDTH(W), .WAIT_STATES(1), .STARVE_LIMIT(4)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1));
  dmem_arbiter #(.WORD_WIDTH(W), .WAIT_STATES(0), .STARVE_LIMIT(4)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0));

  // Requests go to whichever instance sel picks; fields are shared.
  assign bus1.halt = halt;   assign bus0.halt = halt;
  assign bus1.p_req = p_req & ~sel;  assign bus0.p_req = p_req & sel;
  assign bus1.d_req = d_req & ~sel;  assign bus0.d_req = d_req & sel;
  assign bus1.p_wen = p_wen;   assign bus0.p_wen = p_wen;
  assign bus1.p_type = p_type; assign bus0.p_type = p_type;
  assign bus1.p_addr = p_addr; assign bus0.p_addr = p_addr;
  assign bus1.p_wd = p_wd;     assign bus0.p_wd = p_wd;
  assign bus1.d_wen = d_wen;   assign bus0.d_wen = d_wen;
  assign bus1.d_type = d_type; assign bus0.d_type = d_type;
  assign bus1.d_addr = d_addr; assign bus0.d_addr = d_addr;
  assign bus1.d_wd = d_wd;     assign bus0.d_wd = d_wd;
  assign bus1.m_rd = mem[bus1.m_addr[6:2]];
  assign bus0.m_rd = mem[bus0.m_addr[6:2]];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
      mem[4] <= 32'hDEADBEEF;
    end else begin
      if (bus1.m_wen) mem[bus1.m_addr[6:2]] <= bus1.m_wd;
      if (bus0.m_wen) mem[bus0.m_addr[6:2]] <= bus0.m_wd;
    end
  end

  logic         v_men, v_mwen, v_pack, v_dack, v_pstall, v_owner;
  logic [2:0]   v_mtype;
  logic [W-1:0] v_maddr, v_mwd;
  always_comb begin
    v_men = sel ? bus0.m_en : bus1.m_en;
    v_mwen = sel ? bus0.m_wen : bus1.m_wen;
    v_pack = sel ? bus0.p_ack : bus1.p_ack;
    v_dack = sel ? bus0.d_ack : bus1.d_ack;
    v_pstall = sel ? bus0.p_stall : bus1.p_stall;
    v_owner = sel ? bus0.owner : bus1.owner;
    v_mtype = sel ? bus0.m_type : bus1.m_type;
    v_maddr = sel ? bus0.m_addr : bus1.m_addr;
    v_mwd = sel ? bus0.m_wd : bus1.m_wd;
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic         dut;
    logic         owner;
    logic         chk;
    logic [W-1:0] rd;
  } exp_t;
  exp_t sbq[$];

  task automatic push(input logic dut, input logic own, input logic chk, input logic [W-1:0] rd);
    exp_t e;
    e.dut = dut; e.owner = own; e.chk = chk; e.rd = rd;
    sbq.push_back(e);
  endtask

  task automatic mon_ack(input logic dut, input logic pa, input logic da, input logic own,
                         input logic [W-1:0] rdv);
    exp_t e;
    if (pa | da) begin
      n_tests++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_ack: dut %0d ack with empty scoreboard at %0t", dut, $time);
      end else begin
        e = sbq.pop_front();
        check("ack_dut", dut, e.dut);
        check("ack_owner", own, e.owner);
        check("ack_port_d", da, e.owner);
        check("ack_both", pa & da, 0);
        if (e.chk) check("ack_rd", rdv, e.rd);
      end
    end
  endtask

  always @(negedge clk) begin
    mon_ack(1'b0, bus1.p_ack, bus1.d_ack, bus1.owner, bus1.p_ack ? bus1.p_rd : bus1.d_rd);
    mon_ack(1'b1, bus0.p_ack, bus0.d_ack, bus0.owner, bus0.p_ack ? bus0.p_rd : bus0.d_rd);
  end

  // Issue one access on the selected instance and watch it cycle by cycle until ack.
  task automatic do_access(input logic who, input logic wen, input logic [2:0] typ,
                           input logic [W-1:0] addr, input logic [W-1:0] wd, input logic [W-1:0] rd);
    int ws = sel ? 0 : 1;
    int cyc = 0;
    int men_n = 0;
    logic got = 1'b0;
    push(sel, who, !wen, rd);
    if (who) begin
      d_wen = wen; d_type = typ; d_addr = addr; d_wd = wd; d_req = 1'b1;
    end else begin
      p_wen = wen; p_type = typ; p_addr = addr; p_wd = wd; p_req = 1'b1;
    end
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (v_pack | v_dack) begin
        got = 1'b1;
        if (!who) check("p_stall_at_ack", v_pstall, 0);
      end else begin
        if (!who) check("p_stall_wait", v_pstall, 1);
        if (v_men) begin
          men_n++;
          check("m_addr", v_maddr, addr);
          check("m_type", v_mtype, typ);
          check("m_wen_slot", v_mwen, (wen && men_n == ws + 1) ? 1 : 0);
          if (v_mwen) check("m_wd", v_mwd, wd);
        end else begin
          check("m_wen_outside_busy", v_mwen, 0);
        end
      end
    end
    check("ack_seen", got, 1);
    check("ack_latency", cyc, ws + 2);
    check("m_en_cycles", men_n, ws + 1);
    p_req = 1'b0;
    d_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   cyc;
    int   n;
    logic got;
    sel = 1'b0; halt = 1'b0; mem_load = 1'b1;
    p_req = 0; p_wen = 0; p_type = '0; p_addr = '0; p_wd = '0;
    d_req = 0; d_wen = 0; d_type = '0; d_addr = '0; d_wd = '0;

    // Reset state
    @(negedge clk);
    p_req = 1'b1;
    #1;
    check("rst_stall_follows_req", v_pstall, 1);
    check("rst_m_en", v_men, 0);
    check("rst_m_wen", v_mwen, 0);
    check("rst_p_ack", v_pack, 0);
    check("rst_d_ack", v_dack, 0);
    check("rst_owner", v_owner, 0);
    check("rst_m_addr", v_maddr, 0);
    check("rst_p_rd", bus1.p_rd, 0);
    p_req = 1'b0;
    #1 check("rst_stall_low", v_pstall, 0);
    @(negedge clk);
    mem_load = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    // P read, D write, D read-back
    do_access(1'b0, 1'b0, 3'b000, 32'h10, 32'h0, 32'hDEADBEEF);
    @(negedge clk);
    do_access(1'b1, 1'b1, 3'b010, 32'h40, 32'hA5A5A5A5, 32'h0);
    @(negedge clk);
    do_access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'hA5A5A5A5);
    @(negedge clk);

    // Contention: both held; expect P,P,P,P,D,P,P,P,P,D
    p_wen = 0; p_type = 3'b010; p_addr = 32'h10;
    d_wen = 0; d_type = 3'b010; d_addr = 32'h40;
    for (int i = 0; i < 10; i++)
      push(1'b0, (i % 5 == 4), 1'b1, (i % 5 == 4) ? 32'hA5A5A5A5 : 32'hDEADBEEF);
    p_req = 1'b1; d_req = 1'b1;
    n = 0; cyc = 0;
    while (n < 10 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (v_pack | v_dack) begin
        check("contention_owner", v_owner, (n % 5 == 4) ? 1 : 0);
        n++;
      end
    end
    check("contention_acks", n, 10);
    p_req = 1'b0; d_req = 1'b0;
    @(negedge clk);

    // Halt raised during BUSY, then held in IDLE, then released
    p_wen = 0; p_type = 3'b000; p_addr = 32'h10;
    push(1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
    p_req = 1'b1;
    @(negedge clk);
    check("halt_busy_m_en", v_men, 1);
    halt = 1'b1;
    cyc = 1; got = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk); cyc++; got = v_pack;
    end
    check("halt_busy_ack", got, 1);
    check("halt_busy_latency", cyc, 3);
    p_req = 1'b0;
    @(negedge clk);
    p_req = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("halt_idle_m_en", v_men, 0);
      check("halt_idle_stall", v_pstall, 1);
    end
    push(1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
    halt = 1'b0;
    @(negedge clk);
    check("halt_release_grant", v_men, 1);
    cyc = 1; got = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk); cyc++; got = v_pack;
    end
    check("halt_release_ack", got, 1);
    p_req = 1'b0;
    @(negedge clk);

    // Async reset in the write-strobe cycle of a P write
    p_wen = 1; p_type = 3'b111; p_addr = 32'h20; p_wd = 32'h11111111;
    d_wen = 0; d_addr = 32'h40;
    p_req = 1'b1; d_req = 1'b1;
    @(negedge clk);
    check("rstw_first_busy_wen", v_mwen, 0);
    check("rstw_starve_counted", u_dut1.starve, 1);
    @(negedge clk);
    check("rstw_wen_before", v_mwen, 1);
    #2 rst = 1'b0; d_req = 1'b0;
    #1;
    check("rstw_m_en_drop", v_men, 0);
    check("rstw_m_wen_drop", v_mwen, 0);
    check("rstw_starve_clear", u_dut1.starve, 0);
    check("rstw_no_ack", v_pack, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    do_access(1'b0, 1'b1, 3'b111, 32'h20, 32'h11111111, 32'h0);
    @(negedge clk);
    do_access(1'b0, 1'b0, 3'b000, 32'h20, 32'h0, 32'h11111111);
    @(negedge clk);

    // Zero wait-state instance
    sel = 1'b1;
    @(negedge clk);
    do_access(1'b0, 1'b1, 3'b001, 32'h24, 32'h22222222, 32'h0);
    @(negedge clk);
    do_access(1'b1, 1'b0, 3'b001, 32'h24, 32'h0, 32'h22222222);
    @(negedge clk);
    @(negedge clk);

    check("scoreboard_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
